uart_tx_param: RTL and testbench

Parametrised UART transmitter: serialises words of configurable width into asynchronous frames with optional parity and 1 or 2 stop bits. Has an internal baud divisor, a valid/ready input handshake and a one-entry holding buffer, so frames can be sent back-to-back with no idle gap. It sits between the fabric-side command logic and the board TX pin, in the single system clock domain.

---
 rtl/uart_tx_param_pkg.sv | 26 ++
 rtl/uart_tx_param_if.sv | 15 +
 rtl/uart_baud_gen.sv | 37 +++
 rtl/uart_tx_param.sv | 194 +++++++++++++++++++
 tb/tb_uart_tx_param.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_param_pkg.sv
// uart_pkg: shared definitions for the UART transmitter and its future
// receiver sibling.
//   uart_state_e : frame sequencer states
//   PAR_*        : parity mode encodings for the PARITY parameter
//   frame_bits() : bit periods in one frame for a given configuration
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 32'sd0;
  localparam int PAR_EVEN = 32'sd1;
  localparam int PAR_ODD  = 32'sd2;

  // Start bit + payload + optional parity slot + stop bits.
  function automatic int frame_bits(input int data_bits, input int parity,
                                    input int stop_bits);
    return 32'sd1 + data_bits + ((parity != PAR_NONE) ? 32'sd1 : 32'sd0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: valid/ready word handshake into the UART transmitter.
//   data  : payload word (DATA_BITS wide)
//   valid : data is valid
//   ready : transmitter holding buffer is empty
// master = word producer, slave = transmitter.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter shared by the UART TX and RX.
//   clk_i  : system clock
//   rst_i  : synchronous active-high reset
//   clr_i  : synchronous clear, restarts the bit period at count 0
//   tick_o : high in the last clock of each bit period
//   cnt_o  : current position inside the bit period
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            clr_i,
  output logic                            tick_o,
  output logic [$clog2(CLKS_PER_BIT)-1:0] cnt_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_r;

  // Bit-period counter: 0..CLKS_PER_BIT-1, wrapping, clearable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r <= '0;
    end else if (clr_i || (cnt_r == LAST_CNT)) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Tick is a pure decode of the counter register, so it adds no input path.
  assign tick_o = (cnt_r == LAST_CNT);
  assign cnt_o  = cnt_r;

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with a one-word holding buffer.
//   clk_i  : system clock
//   rst_i  : synchronous active-high reset
//   bus    : valid/ready word input (slave side)
//   tx_o   : serial line, idles high
//   busy_o : frame on the line or holding buffer occupied
//   done_o : one-cycle pulse in the last clock of each frame
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic             clk_i,
  input  logic             rst_i,
  uart_tx_param_if.slave   bus,
  output logic             tx_o,
  output logic             busy_o,
  output logic             done_o
);

  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
    $fatal(1, "uart_tx_param: DATA_BITS must be 5..9");
  end
  if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
    $fatal(1, "uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
    $fatal(1, "uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_divisor
    $fatal(1, "uart_tx_param: CLKS_PER_BIT must be >= 2");
  end

  localparam int BIT_CNT_W = $clog2(DATA_BITS);
  localparam int CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);
  // Count value one clock before the bit period ends; done_o is registered
  // so it must be decided one clock early.
  localparam logic [CNT_W-1:0]     PRE_LAST  = CNT_W'(CLKS_PER_BIT - 2);

  uart_state_e            state_r, state_s;
  logic [BIT_CNT_W-1:0]   bit_cnt_r, bit_cnt_s;
  logic                   buf_full_r, buf_full_s;
  logic [DATA_BITS-1:0]   buf_data_r, buf_data_s;
  logic [DATA_BITS-1:0]   word_r, word_s;
  logic                   par_r, par_s;
  logic                   tx_r, tx_s;
  logic                   ready_r, busy_r, done_r, done_s;
  logic                   load_s, accept_s, tick_s;
  logic [CNT_W-1:0]       baud_cnt_s;

  // Holding the counter clear while idle keeps the first start bit full length.
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (load_s || (state_r == S_IDLE)),
    .tick_o (tick_s),
    .cnt_o  (baud_cnt_s)
  );

  // Frame sequencer: next state, bit counter, load and end-of-frame decode.
  always_comb begin
    state_s   = state_r;
    bit_cnt_s = bit_cnt_r;
    load_s    = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (buf_full_r) begin
          state_s = S_START;
          load_s  = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_START: begin
        if (tick_s) begin
          state_s   = S_DATA;
          bit_cnt_s = '0;
        end else begin
          state_s   = S_START;
        end
      end
      S_DATA: begin
        if (tick_s && (bit_cnt_r == LAST_DATA)) begin
          state_s   = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
          bit_cnt_s = '0;
        end else if (tick_s) begin
          bit_cnt_s = bit_cnt_r + BIT_CNT_W'(1);
        end else begin
          bit_cnt_s = bit_cnt_r;
        end
      end
      S_PARITY: begin
        if (tick_s) begin
          state_s   = S_STOP;
          bit_cnt_s = '0;
        end else begin
          state_s   = S_PARITY;
        end
      end
      S_STOP: begin
        if (bit_cnt_r == LAST_STOP) begin
          done_s = (baud_cnt_s == PRE_LAST);
          if (tick_s) begin
            // A full buffer chains straight into the next start bit.
            bit_cnt_s = '0;
            load_s    = buf_full_r;
            state_s   = buf_full_r ? S_START : S_IDLE;
          end else begin
            state_s   = S_STOP;
          end
        end else if (tick_s) begin
          bit_cnt_s = bit_cnt_r + BIT_CNT_W'(1);
        end else begin
          bit_cnt_s = bit_cnt_r;
        end
      end
      default: begin
        state_s   = S_IDLE;
        bit_cnt_s = '0;
      end
    endcase
  end

  // Holding buffer, captured word/parity and next line level.
  always_comb begin
    accept_s   = bus.valid && ready_r;
    buf_full_s = buf_full_r;
    buf_data_s = buf_data_r;
    word_s     = word_r;
    par_s      = par_r;
    if (accept_s) begin
      buf_full_s = 1'b1;
      buf_data_s = bus.data;
    end else if (load_s) begin
      buf_full_s = 1'b0;
    end else begin
      buf_full_s = buf_full_r;
    end
    // Parity comes from the word captured at load, never from live input.
    if (load_s) begin
      word_s = buf_data_r;
      par_s  = (PARITY == PAR_ODD) ? ~^buf_data_r : ^buf_data_r;
    end else begin
      word_s = word_r;
    end
    case (state_s)
      S_IDLE:   tx_s = 1'b1;
      S_START:  tx_s = 1'b0;
      S_DATA:   tx_s = word_s[bit_cnt_s];
      S_PARITY: tx_s = par_s;
      S_STOP:   tx_s = 1'b1;
      default:  tx_s = 1'b1;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= S_IDLE;
      bit_cnt_r  <= '0;
      buf_full_r <= 1'b0;
      buf_data_r <= '0;
      word_r     <= '0;
      par_r      <= 1'b0;
      tx_r       <= 1'b1;
      ready_r    <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      bit_cnt_r  <= bit_cnt_s;
      buf_full_r <= buf_full_s;
      buf_data_r <= buf_data_s;
      word_r     <= word_s;
      par_r      <= par_s;
      tx_r       <= tx_s;
      ready_r    <= !buf_full_s;
      busy_r     <= (state_s != S_IDLE) || buf_full_s;
      done_r     <= done_s;
    end
  end

  assign bus.ready = ready_r;
  assign tx_o      = tx_r;
  assign busy_o    = busy_r;
  assign done_o    = done_r;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three configurations side by side, words driven
// through the valid/ready interface and every line cycle compared against a
// frame model built from the framing rules.
module tb_uart_tx_param;
  import uart_pkg::*;

  localparam int DB  [3] = '{8, 7, 5};
  localparam int PAR [3] = '{PAR_EVEN, PAR_ODD, PAR_NONE};
  localparam int SB  [3] = '{1, 2, 1};
  localparam int CPB [3] = '{4, 3, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] data_d [3];
  logic [2:0] valid_d;
  logic [2:0] tx_w, busy_w, done_w, rdy_w;
  logic [8:0] wq [$];
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  uart_tx_param_if #(.DATA_BITS(DB[0])) if_a ();
  uart_tx_param_if #(.DATA_BITS(DB[1])) if_b ();
  uart_tx_param_if #(.DATA_BITS(DB[2])) if_c ();

  assign if_a.data  = data_d[0][7:0];
  assign if_b.data  = data_d[1][6:0];
  assign if_c.data  = data_d[2][4:0];
  assign if_a.valid = valid_d[0];
  assign if_b.valid = valid_d[1];
  assign if_c.valid = valid_d[2];
  assign rdy_w[0]   = if_a.ready;
  assign rdy_w[1]   = if_b.ready;
  assign rdy_w[2]   = if_c.ready;

  uart_tx_param #(.DATA_BITS(DB[0]), .PARITY(PAR[0]), .STOP_BITS(SB[0]), .CLKS_PER_BIT(CPB[0]))
    u_dut_a (.clk_i(clk), .rst_i(rst), .bus(if_a), .tx_o(tx_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0]));
  uart_tx_param #(.DATA_BITS(DB[1]), .PARITY(PAR[1]), .STOP_BITS(SB[1]), .CLKS_PER_BIT(CPB[1]))
    u_dut_b (.clk_i(clk), .rst_i(rst), .bus(if_b), .tx_o(tx_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1]));
  uart_tx_param #(.DATA_BITS(DB[2]), .PARITY(PAR[2]), .STOP_BITS(SB[2]), .CLKS_PER_BIT(CPB[2]))
    u_dut_c (.clk_i(clk), .rst_i(rst), .bus(if_c), .tx_o(tx_w[2]), .busy_o(busy_w[2]), .done_o(done_w[2]));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Line level of bit period idx in the frame carrying word w on DUT d.
  function automatic int exp_bit(input int d, input logic [8:0] w, input int idx);
    logic [8:0] m;
    m = w & 9'((32'd1 << DB[d]) - 32'd1);
    if (idx == 0) return 0;
    if (idx <= DB[d]) return int'(m[idx-1]);
    if ((PAR[d] != PAR_NONE) && (idx == DB[d] + 1))
      return (PAR[d] == PAR_EVEN) ? ($countones(m) % 2) : (1 - ($countones(m) % 2));
    return 1;
  endfunction

  // Offer each queued word; while stalled, valid stays high with junk data.
  task automatic drive(input int d);
    for (int k = 0; k < wq.size(); k++) begin
      int guard = 0;
      while (rdy_w[d] !== 1'b1 && guard < 200) begin
        data_d[d]  = 9'($urandom);
        valid_d[d] = 1'b1;
        @(negedge clk);
        guard++;
      end
      chk("drive_ready_seen", (guard < 200) ? 1 : 0, 1);
      data_d[d]  = wq[k];
      valid_d[d] = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    valid_d[d] = 1'b0;
  endtask

  // Expect every queued word once, in order, as gap-free frames.
  task automatic check_stream(input int d);
    int n    = wq.size();
    int flen = frame_bits(DB[d], PAR[d], SB[d]) * CPB[d];
    int lat  = 0;
    while (tx_w[d] !== 1'b0 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("start_latency", lat, 2);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < flen; c++) begin
        if (!(k == 0 && c == 0)) @(negedge clk);
        chk($sformatf("tx_d%0d_w%0d_c%0d", d, k, c), int'(tx_w[d]), exp_bit(d, wq[k], c / CPB[d]));
        chk($sformatf("done_d%0d_w%0d_c%0d", d, k, c), int'(done_w[d]), (c == flen - 1) ? 1 : 0);
        chk("busy_in_frame", int'(busy_w[d]), 1);
        if (c == 0) chk("ready_at_load", int'(rdy_w[d]), 1);
        if (c == 1) chk("ready_after_load", int'(rdy_w[d]), (k < n - 1) ? 0 : 1);
      end
    end
    @(negedge clk);
    chk("end_tx", int'(tx_w[d]), 1);
    chk("end_done", int'(done_w[d]), 0);
    chk("end_busy", int'(busy_w[d]), 0);
    chk("end_ready", int'(rdy_w[d]), 1);
  endtask

  task automatic run(input int d);
    fork
      drive(d);
      check_stream(d);
    join
  endtask

  initial begin
    rst     = 1'b1;
    valid_d = 3'b000;
    for (int i = 0; i < 3; i++) data_d[i] = 9'h000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset_tx", int'(tx_w[d]), 1);
      chk("reset_ready", int'(rdy_w[d]), 1);
      chk("reset_busy", int'(busy_w[d]), 0);
      chk("reset_done", int'(done_w[d]), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed frames from the plan, one per configuration.
    wq = '{9'h0A5};          run(0);
    wq = '{9'h07F};          run(1);
    wq = '{9'h015};          run(2);
    // Back-to-back pair on the 8-bit even-parity unit.
    wq = '{9'h000, 9'h0FF};  run(0);

    // Random streams with junk data during every stall.
    for (int d = 0; d < 3; d++) begin
      wq.delete();
      for (int i = 0; i < 4; i++) wq.push_back(9'($urandom));
      run(d);
    end

    // Reset in the middle of payload bit 3.
    data_d[0]  = 9'h1C3;
    valid_d[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_d[0] = 1'b0;
    @(negedge clk);
    chk("rst_case_start", int'(tx_w[0]), 0);
    repeat (17) @(negedge clk);
    chk("rst_case_bit3", int'(tx_w[0]), exp_bit(0, 9'h1C3, 4));
    chk("rst_case_busy", int'(busy_w[0]), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_tx", int'(tx_w[0]), 1);
    chk("rst_mid_ready", int'(rdy_w[0]), 1);
    chk("rst_mid_busy", int'(busy_w[0]), 0);
    chk("rst_mid_done", int'(done_w[0]), 0);
    begin
      int dn  = 0;
      int low = 0;
      repeat (60) begin
        @(negedge clk);
        dn  += int'(done_w[0]);
        low += int'(!tx_w[0]);
      end
      chk("rst_no_done", dn, 0);
      chk("rst_line_idle", low, 0);
    end
    wq = '{9'($urandom)};
    run(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
